display_scan_controller: RTL and testbench

Time-multiplexes the four-digit seven-segment display between the hours and minutes digit pairs, one digit per scan slot. Sits between the time counters, the set-mode FSM and the display pins. It consumes the FSM's digit-blink and dot enables and produces registered anode and segment drives. A blanking interval between slots suppresses ghosting. Blink and dot phases are generated internally.

---
 rtl/display_scan_controller_pkg.sv | 36 +++
 rtl/display_scan_controller_bcd_to_7seg.sv | 27 ++
 rtl/display_scan_controller.sv | 191 +++++++++++++++++++
 tb/tb_display_scan_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the four-digit seven-segment scan controller:
// scan FSM encodings, digit index constants, segment patterns and the
// slot-length derivation.
package display_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Scan order: minutes ones, minutes tens, hours ones, hours tens.
  localparam logic [1:0] IDX_MIN_ONES = 2'd0;
  localparam logic [1:0] IDX_MIN_TENS = 2'd1;
  localparam logic [1:0] IDX_HR_ONES  = 2'd2;
  localparam logic [1:0] IDX_HR_TENS  = 2'd3;

  // Active-low segment patterns, bit order [6:0] = g..a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Clock cycles per digit slot: a full frame covers four digits.
  function automatic int slot_cycles(input int clk_hz, input int scan_hz);
    return clk_hz / (scan_hz * 4);
  endfunction

endpackage

// File: rtl/display_scan_controller_bcd_to_7seg.sv
// bcd_to_7seg: combinational BCD nibble to active-low seven-segment pattern.
// Values above 9 produce a blank digit.
module bcd_to_7seg
  import display_scan_controller_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decode one nibble; the default arm keeps every path assigned.
  always_comb begin
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexes hours/minutes onto a four-digit
// seven-segment display with an anode-off blanking gap per slot, digit blink
// for the field being set, and a seconds dot on the hours-ones digit.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module display_scan_controller
  import display_scan_controller_pkg::*;
#(
  parameter int CLK_HZ       = 25_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_HZ     = 2,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [7:0] i_Hours_BCD,
  input  logic [7:0] i_Minutes_BCD,
  input  logic [1:0] i_Display_Enable_Digits,
  input  logic       i_Display_Enable_Dot,
  input  logic       i_Second_Tick,
  output logic [3:0] o_Digit_Select,
  output logic [6:0] o_Segments,
  output logic       o_Dot
);

  localparam int SLOT_CYCLES  = slot_cycles(CLK_HZ, SCAN_HZ);
  localparam int DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES - 1;
  localparam int CNT_W        = $clog2(SLOT_CYCLES + 1);
  localparam int BLINK_HALF   = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLINK_W      = $clog2(BLINK_HALF + 1);

  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  if (BLANK_CYCLES < 1 || SLOT_CYCLES < BLANK_CYCLES + 2) begin : g_cfg_check
    $error("display_scan_controller: SLOT_CYCLES must be at least BLANK_CYCLES+2");
  end

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic [1:0]         en_prev_q;
  logic               sec_phase_q, sec_phase_d;
  logic [3:0]         anode_q, anode_d;
  logic [6:0]         seg_q, seg_d;
  logic               dot_q, dot_d;

  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic [3:0] anode_sel;
  logic       pair_blinks;
  logic       en_changed;
  logic       blink_gate;

  // Slot sequencing: BLANK for BLANK_CYCLES, one LOAD, then DRIVE to slot end.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Pick the BCD nibble for the digit currently being scanned.
  always_comb begin
    nibble = 4'h0;
    case (idx_q)
      IDX_MIN_ONES: nibble = i_Minutes_BCD[3:0];
      IDX_MIN_TENS: nibble = i_Minutes_BCD[7:4];
      IDX_HR_ONES:  nibble = i_Hours_BCD[3:0];
      default:      nibble = i_Hours_BCD[7:4];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // A zero hours-tens digit is shown as a blank rather than "0".
    if (idx_q == IDX_HR_TENS && i_Hours_BCD[7:4] == 4'h0) nibble = 4'hF;
`endif
  end

  bcd_to_7seg u_bcd_to_7seg (
    .bcd_i (nibble),
    .seg_o (seg_dec)
  );

  // Blink gating: a change of the enables counts as phase ON this cycle so
  // a newly selected field is never loaded dark.
  always_comb begin
    anode_sel   = ~(4'b0001 << idx_q);
    pair_blinks = idx_q[1] ? i_Display_Enable_Digits[1] : i_Display_Enable_Digits[0];
    en_changed  = (i_Display_Enable_Digits != en_prev_q);
    blink_gate  = pair_blinks && !(blink_on_q || en_changed);
  end

  // Blink half-period counter and seconds-dot phase.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (en_changed) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Disabling the dot clears the phase even if a tick arrives together.
    if (!i_Display_Enable_Dot)  sec_phase_d = 1'b0;
    else if (i_Second_Tick)     sec_phase_d = !sec_phase_q;
    else                        sec_phase_d = sec_phase_q;
  end

  // Output drive: latched at LOAD, held through DRIVE, blank otherwise.
  always_comb begin
    anode_d = 4'hF;
    seg_d   = SEG_BLANK;
    dot_d   = 1'b1;
    if (state_q == ST_LOAD) begin
      anode_d = blink_gate ? 4'hF : anode_sel;
      seg_d   = seg_dec;
      dot_d   = !((idx_q == IDX_HR_ONES) && i_Display_Enable_Dot && sec_phase_q);
    end else if (state_q == ST_DRIVE && state_d == ST_DRIVE) begin
      anode_d = anode_q;
      seg_d   = seg_q;
      dot_d   = dot_q;
    end
  end

  // State and output registers; reset forces every anode off at once.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= IDX_MIN_ONES;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      en_prev_q   <= 2'b00;
      sec_phase_q <= 1'b0;
      anode_q     <= 4'hF;
      seg_q       <= SEG_BLANK;
      dot_q       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      en_prev_q   <= i_Display_Enable_Digits;
      sec_phase_q <= sec_phase_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dot_q       <= dot_d;
    end
  end

  assign o_Digit_Select = anode_q;
  assign o_Segments     = seg_q;
  assign o_Dot          = dot_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a small configuration:
// SLOT_CYCLES = 4 (1 blank, 1 load, 2 drive) and a 400-cycle blink half-period.
module tb_display_scan_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [1:0] en_digits;
  logic       en_dot;
  logic       tick;
  logic [3:0] dig;
  logic [6:0] seg;
  logic       dot;

  int checks = 0;
  int errors = 0;

  display_scan_controller #(
    .CLK_HZ       (1600),
    .SCAN_HZ      (100),
    .BLINK_HZ     (2),
    .BLANK_CYCLES (1)
  ) dut (
    .i_Clock                 (clk),
    .i_Reset_n               (rst_n),
    .i_Hours_BCD             (hours),
    .i_Minutes_BCD           (minutes),
    .i_Display_Enable_Digits (en_digits),
    .i_Display_Enable_Dot    (en_dot),
    .i_Second_Tick           (tick),
    .o_Digit_Select          (dig),
    .o_Segments              (seg),
    .o_Dot                   (dot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) until the given anode pattern is sampled.
  task automatic wait_anode(input logic [3:0] target, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (dig === target) ok = 1'b1;
    end
  endtask

  // Wait for a fresh assertion of the given anode (not the one in progress).
  task automatic wait_fresh(input logic [3:0] target, output bit ok);
    int n;
    n = 0;
    while (dig === target && n < 40) begin
      @(negedge clk);
      n++;
    end
    wait_anode(target, ok);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    hours     = 8'h12;
    minutes   = 8'h34;
    en_digits = 2'b00;
    en_dot    = 1'b0;
    tick      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dig !== 4'hF) begin errors++; $display("FAIL reset_anode: got %h want F", dig); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7F", seg); end
    checks++;
    if (dot !== 1'b1) begin errors++; $display("FAIL reset_dot: got %b want 1", dot); end
    rst_n = 1'b1;
  endtask

  // Two frames straight after reset release: first anode after 2 cycles.
  task automatic test_scan();
    logic [3:0] an_tbl [4];
    logic [6:0] seg_tbl [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int p;
    an_tbl  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_tbl = '{7'h19, 7'h30, 7'h24, 7'h79};
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      p = k % 16;
      if ((p % 4) >= 2) begin
        exp_an  = an_tbl[p / 4];
        exp_seg = seg_tbl[p / 4];
      end else begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
      end
      checks++;
      if (dig !== exp_an) begin
        errors++; $display("FAIL scan_anode k=%0d: got %h want %h", k, dig, exp_an);
      end
      checks++;
      if (seg !== exp_seg) begin
        errors++; $display("FAIL scan_seg k=%0d: got %h want %h", k, seg, exp_seg);
      end
    end
  endtask

  task automatic test_bad_nibble();
    bit ok;
    minutes = 8'h3A;
    wait_fresh(4'hE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bad_nibble_sync: anode E not seen, last %h", dig); end
    checks++;
    if (seg !== 7'h7F) begin errors++; $display("FAIL bad_nibble_seg: got %h want 7F", seg); end
    @(negedge clk);
    checks++;
    if (dig !== 4'hE || seg !== 7'h7F) begin
      errors++; $display("FAIL bad_nibble_hold: got %h/%h want E/7F", dig, seg);
    end
    wait_anode(4'hD, ok);
    checks++;
    if (!ok || seg !== 7'h30) begin
      errors++; $display("FAIL bad_nibble_tens: got %h/%h want D/30", dig, seg);
    end
    minutes = 8'h34;
  endtask

  task automatic test_blink();
    bit ok;
    int min_on, min_off, hr_off;
    min_on = 0; min_off = 0; hr_off = 0;
    wait_fresh(4'hE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL blink_sync: anode E not seen, last %h", dig); end
    en_digits = 2'b01;
    for (int k = 1; k <= 1232; k++) begin
      @(negedge clk);
      if (k <= 400 && (dig === 4'hE || dig === 4'hD)) min_on++;
      if (k >= 404 && k <= 800 && (dig === 4'hE || dig === 4'hD)) min_off++;
      if (k >= 404 && k <= 800 && (dig === 4'hB || dig === 4'h7)) hr_off++;
      if (k == 816) begin
        checks++;
        if (dig !== 4'hE) begin errors++; $display("FAIL blink_back_on: got %h want E", dig); end
      end
      if (k == 1216) begin
        checks++;
        if (dig !== 4'hF) begin errors++; $display("FAIL blink_gated: got %h want F", dig); end
        en_digits = 2'b10;
      end
      if (k == 1220) begin
        checks++;
        if (dig !== 4'hD) begin errors++; $display("FAIL switch_min_tens: got %h want D", dig); end
      end
      if (k == 1224) begin
        checks++;
        if (dig !== 4'hB) begin errors++; $display("FAIL switch_hr_ones: got %h want B", dig); end
      end
      if (k == 1228) begin
        checks++;
        if (dig !== 4'h7) begin errors++; $display("FAIL switch_hr_tens: got %h want 7", dig); end
      end
      if (k == 1232) begin
        checks++;
        if (dig !== 4'hE) begin errors++; $display("FAIL switch_min_ones: got %h want E", dig); end
      end
    end
    checks++;
    if (min_on != 100) begin errors++; $display("FAIL blink_min_on_count: got %0d want 100", min_on); end
    checks++;
    if (min_off != 0) begin errors++; $display("FAIL blink_min_off_count: got %0d want 0", min_off); end
    checks++;
    if (hr_off != 100) begin errors++; $display("FAIL blink_hr_count: got %0d want 100", hr_off); end
    en_digits = 2'b00;
  endtask

  task automatic test_dot();
    bit ok;
    int low_early, low_late, stray;
    low_early = 0; low_late = 0; stray = 0;
    wait_fresh(4'hB, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dot_sync: anode B not seen, last %h", dig); end
    en_dot = 1'b1;
    for (int q = 1; q <= 700; q++) begin
      @(negedge clk);
      if (dot === 1'b0 && q <= 400) low_early++;
      if (dot === 1'b0 && q > 400)  low_late++;
      if (dot === 1'b0 && dig !== 4'hB) stray++;
      if (q == 96 || q == 304) begin
        checks++;
        if (dot !== 1'b1) begin errors++; $display("FAIL dot_off q=%0d: got %b want 1", q, dot); end
      end
      if (q == 112 || q == 288) begin
        checks++;
        if (dot !== 1'b0) begin errors++; $display("FAIL dot_on q=%0d: got %b want 0", q, dot); end
      end
      if (q == 100 || q == 300) tick = 1'b1;
      if (q == 101 || q == 301) tick = 1'b0;
      if (q == 500) begin en_dot = 1'b0; tick = 1'b1; end
      if (q == 501) begin en_dot = 1'b1; tick = 1'b0; end
    end
    checks++;
    if (low_early != 24) begin errors++; $display("FAIL dot_low_count: got %0d want 24", low_early); end
    checks++;
    if (low_late != 0) begin errors++; $display("FAIL dot_clear_wins: got %0d low cycles want 0", low_late); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL dot_wrong_digit: got %0d cycles want 0", stray); end
    en_dot = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    bit ok;
    wait_fresh(4'hB, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_sync: anode B not seen, last %h", dig); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dig !== 4'hF || seg !== 7'h7F || dot !== 1'b1) begin
      errors++; $display("FAIL rst_async: got %h/%h/%b want F/7F/1", dig, seg, dot);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dig !== 4'hF) begin errors++; $display("FAIL rst_release_1: got %h want F", dig); end
    @(negedge clk);
    checks++;
    if (dig !== 4'hE || seg !== 7'h19) begin
      errors++; $display("FAIL rst_release_2: got %h/%h want E/19", dig, seg);
    end
  endtask

  task automatic test_leading_zero();
    bit ok;
    logic [6:0] exp_tens;
`ifdef LEADING_ZERO_BLANK_EN
    exp_tens = 7'h7F;
`else
    exp_tens = 7'h40;
`endif
    hours = 8'h09;
    wait_fresh(4'h7, ok);
    checks++;
    if (!ok || seg !== exp_tens) begin
      errors++; $display("FAIL hr_tens_zero: got %h/%h want 7/%h", dig, seg, exp_tens);
    end
    wait_anode(4'hB, ok);
    checks++;
    if (!ok || seg !== 7'h10) begin
      errors++; $display("FAIL hr_ones_nine: got %h/%h want B/10", dig, seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bad_nibble();
    test_blink();
    test_dot();
    test_reset_mid_drive();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
